// File: rtl/fifo_rd_stream.sv
// Read-side controller for fifo_syn: drains the FIFO (one-cycle read latency) into a
// valid/ready stream through a 2-entry skid buffer, with a frame marker every BURST_LEN beats.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  rd_reg,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam logic [CNT_WIDTH-1:0] LastBeat = CNT_WIDTH'(BURST_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  head_q, tail_q;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q;
  logic                  pop;
  logic [2:0]            committed;

  // Stream outputs come straight from the buffer head.
  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = buf_q[head_q];
  assign m_last   = m_valid && (beat_cnt_q == LastBeat);
  assign word_cnt = word_cnt_q;

  // Read credit check and next-state for occupancy and frame position.
  always_comb begin
    pop        = m_valid && m_ready;
    // Slots still owed after this cycle: buffered plus arriving, minus leaving.
    committed  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    // Reset gates the strobe so no FIFO word is consumed while state is being cleared.
    rd_reg     = !rst && en && !fifo_empty && (committed < 3'd2);
    occ_d      = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = (beat_cnt_q == LastBeat) ? '0 : beat_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Buffer, pointers, in-flight flag and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      beat_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= rd_reg;
      beat_cnt_q <= beat_cnt_d;
      if (inflight_q) begin
        buf_q[tail_q] <= fifo_data;
        tail_q        <= ~tail_q;
      end
      if (pop) begin
        head_q     <= ~head_q;
        word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO and stream model drive two DUTs
// (BURST_LEN 4 and 1) with directed and random traffic and check every cycle.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, fifo_empty, m_ready;
  logic [DW-1:0] fifo_data;
  logic          rd_a, rd_b, valid_a, valid_b, last_a, last_b;
  logic [DW-1:0] data_a, data_b;
  logic [CW-1:0] wcnt_a, wcnt_b;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(4), .CNT_WIDTH(CW)) dut_a (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_reg(rd_a), .m_data(data_a), .m_valid(valid_a), .m_ready(m_ready),
    .m_last(last_a), .word_cnt(wcnt_a)
  );

  fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(1), .CNT_WIDTH(CW)) dut_b (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .rd_reg(rd_b), .m_data(data_b), .m_valid(valid_b), .m_ready(m_ready),
    .m_last(last_b), .word_cnt(wcnt_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] fifo_q[$];  // upstream FIFO contents
  logic [DW-1:0] mbuf[$];    // words read from the FIFO, arrived, not yet delivered
  bit            m_inflight;
  int            delivered;  // beats accepted since last reset
  bit            known;
  logic [DW-1:0] next_word;

  // Per-cycle samples and running tallies for directed checks.
  bit            s_rd, s_valid, s_last_a, s_last_b;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_wcnt;
  int            rds, beats, lasts_a, lasts_b;
  logic [DW-1:0] last_a_data;

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic push();
    fifo_q.push_back(next_word);
    next_word = next_word + 8'd1;
    fifo_empty = 1'b0;
  endtask

  // One clock: compare at negedge against the model, then advance the model after posedge.
  task automatic cycle();
    bit exp_valid, exp_rd, pop_m, rd_now;
    int lvl;
    @(negedge clk);
    s_rd = rd_a; s_valid = valid_a; s_data = data_a;
    s_last_a = last_a; s_last_b = last_b; s_wcnt = wcnt_a;
    exp_valid = (mbuf.size() != 0);
    pop_m = exp_valid && m_ready;
    lvl = mbuf.size() + int'(m_inflight) - int'(pop_m);
    exp_rd = !rst && en && (fifo_q.size() != 0) && (lvl < 2);
    if (known) begin
      check("rd_reg", rd_a, exp_rd);
      check("rd_reg_bl1", rd_b, exp_rd);
      check("m_valid", valid_a, exp_valid);
      check("m_valid_bl1", valid_b, exp_valid);
      if (exp_valid) begin
        check("m_data", data_a, mbuf[0]);
        check("m_data_bl1", data_b, mbuf[0]);
      end
      check("m_last_bl4", last_a, exp_valid && (delivered % 4 == 3));
      check("m_last_bl1", last_b, exp_valid);
      check("word_cnt", wcnt_a, delivered % 65536);
      check("word_cnt_bl1", wcnt_b, delivered % 65536);
    end
    if (rd_a) rds++;
    if (valid_a && m_ready) begin
      beats++;
      if (last_a) begin lasts_a++; last_a_data = data_a; end
      if (last_b) lasts_b++;
    end
    rd_now = rd_a;
    @(posedge clk);
    #1;
    if (rst) begin
      mbuf.delete();
      m_inflight = 1'b0;
      delivered = 0;
      known = 1'b1;
    end else begin
      if (pop_m) begin void'(mbuf.pop_front()); delivered++; end
      if (m_inflight) mbuf.push_back(fifo_data);
      m_inflight = exp_rd;
    end
    if (rd_now && fifo_q.size() != 0) fifo_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  initial begin
    logic [DW-1:0] first;
    int snap_rd, snap_beats;
    rst = 1'b1; en = 1'b1; m_ready = 1'b1; fifo_data = '0; fifo_empty = 1'b1;
    known = 1'b0; delivered = 0; m_inflight = 1'b0; next_word = 8'h01;
    rds = 0; beats = 0; lasts_a = 0; lasts_b = 0; last_a_data = '0;

    // Reset with words waiting upstream: nothing may be read or presented.
    repeat (5) push();
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i > 0) begin
        check("rst_rd", s_rd, 0);
        check("rst_valid", s_valid, 0);
        check("rst_data", s_data, 0);
        check("rst_last", s_last_a, 0);
        check("rst_wcnt", s_wcnt, 0);
      end
    end
    rst = 1'b0;

    // Preloaded 0x01..0x05 streams out from cycle 2 at one beat per cycle.
    rds = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (c == 0) check("t1_rd_c0", s_rd, 1);
      if (c < 2) check("t1_valid_early", s_valid, 0);
      if (c >= 2 && c <= 6) begin
        check("t1_valid", s_valid, 1);
        check("t1_data", s_data, c - 1);
      end
      if (c == 9) check("t1_rd_drop", s_rd, 0);
    end
    check("t1_wcnt", s_wcnt, 5);
    check("t1_reads", rds, 5);

    // Framing: 10 beats after reset give m_last on beats 4 and 8 for BURST_LEN=4.
    rst = 1'b1; cycle(); rst = 1'b0;
    lasts_a = 0; lasts_b = 0;
    repeat (10) push();
    repeat (15) cycle();
    check("bl4_lasts", lasts_a, 2);
    check("bl1_lasts", lasts_b, 10);
    // Frame position is 2, so the 2nd of the next two words closes the frame.
    lasts_a = 0;
    repeat (2) push();
    repeat (6) cycle();
    check("bl4_pos_lasts", lasts_a, 1);
    check("bl4_pos_data", last_a_data, 8'h11);

    // Alternating backpressure: all 20 words delivered once, in order.
    snap_beats = beats;
    repeat (20) push();
    for (int c = 0; c < 60; c++) begin
      cycle();
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    repeat (3) cycle();
    check("toggle_beats", beats - snap_beats, 20);
    check("toggle_wcnt", s_wcnt, 32);

    // Stall: only two reads fit the buffer; release gives one beat per cycle.
    m_ready = 1'b0;
    first = next_word;
    snap_rd = rds;
    repeat (10) push();
    repeat (8) cycle();
    check("stall_reads", rds - snap_rd, 2);
    check("stall_rd_now", s_rd, 0);
    check("stall_head", s_data, first);
    m_ready = 1'b1;
    snap_beats = beats;
    repeat (10) cycle();
    check("stall_release_beats", beats - snap_beats, 10);

    // Random en / m_ready / arrivals.
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 3) != 0);
      m_ready = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 2) == 0) push();
      cycle();
    end
    en = 1'b1; m_ready = 1'b1;
    repeat (30) cycle();

    // en drops with a read in flight: that word still arrives and is delivered.
    first = next_word;
    repeat (6) push();
    for (int c = 0; c < 5 && !s_rd; c++) cycle();
    check("en_rd_seen", s_rd, 1);
    en = 1'b0;
    snap_rd = rds; snap_beats = beats; last_a_data = '0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (c == 1) check("en_inflight_data", s_data, first);
    end
    check("en_no_reads", rds - snap_rd, 0);
    check("en_drain_beats", beats - snap_beats, 1);

    // Reset mid-stream clears everything by the next cycle.
    en = 1'b1;
    repeat (3) cycle();
    m_ready = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;
    cycle();
    check("midrst_valid", s_valid, 0);
    check("midrst_wcnt", s_wcnt, 0);
    m_ready = 1'b1;
    repeat (20) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
